// File: rtl/ascon_perm_iter.sv
// Iterative ASCON permutation: one round (pc, ps, pl) per clock over a 320-bit state register.
// mode_i selects p^a (constant indices from 12-ROUNDS_A) or p^b (from 12-ROUNDS_B) up to 11.
module ascon_perm_iter #(
    parameter int unsigned ROUNDS_A = 12,
    parameter int unsigned ROUNDS_B = 6
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [4:0][63:0] state_i,
    output logic [4:0][63:0] state_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [0:0] {StIdle, StRun} st_e;

    localparam logic [3:0] R0_A     = 4'(12 - ROUNDS_A);
    localparam logic [3:0] R0_B     = 4'(12 - ROUNDS_B);
    localparam logic [3:0] RND_LAST = 4'd11;

    st_e              st_q;
    logic [3:0]       rnd_q;
    logic [4:0][63:0] state_q;
    logic             busy_q;
    logic             done_q;

    logic [3:0]       rnd_sel;
    logic [4:0][63:0] state_sel;
    logic [4:0][63:0] state_d;

    function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [4:0][63:0] ascon_round(input logic [4:0][63:0] s,
                                                     input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        logic [3:0]  c;
        c  = 4'hF - r;
        x0 = s[0];
        x1 = s[1];
        x2 = s[2] ^ {56'd0, c, r};
        x3 = s[3];
        x4 = s[4];
        // Bitsliced S-box, x0 is the MSB of each 5-bit column.
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x4, x3, x2, x1, x0};
    endfunction

    // The single round datapath is shared between the start round and the RUN rounds.
    always_comb begin
        rnd_sel   = rnd_q;
        state_sel = state_q;
        if (st_q == StIdle) begin
            rnd_sel   = mode_i ? R0_B : R0_A;
            state_sel = state_i;
        end
        state_d = ascon_round(state_sel, rnd_sel);
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            st_q    <= StIdle;
            rnd_q   <= 4'd0;
            state_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (st_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q <= state_d;
                        if (rnd_sel == RND_LAST) begin
                            rnd_q  <= RND_LAST;
                            done_q <= 1'b1;
                        end else begin
                            rnd_q  <= rnd_sel + 4'd1;
                            st_q   <= StRun;
                            busy_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    state_q <= state_d;
                    if (rnd_q == RND_LAST) begin
                        st_q   <= StIdle;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                default: st_q <= StIdle;
            endcase
        end
    end

    assign state_o = state_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule
